// File: rtl/multinoc_eject_ni.sv
// Ejection network interface: merges the local outputs of both BLESS router planes into one
// FIFO toward the PE. The routers cannot be stalled, so flits that do not fit are dropped and counted.
module multinoc_eject_ni #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] ej_flit1,
  input  logic [FLIT_W-1:0] ej_flit2,
  output logic [FLIT_W-1:0] pe_flit,
  output logic              pe_valid,
  input  logic              pe_ready,
  output logic [PTR_W:0]    occupancy,
  output logic [15:0]       drop_cnt,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam logic [PTR_W+1:0] DEPTH_V = (PTR_W+2)'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr2;
  logic [PTR_W:0]    occ_q;
  logic [PTR_W:0]    occ_next;
  logic [PTR_W+1:0]  space;
  logic [15:0]       drop_q;
  logic [16:0]       drop_sum;
  logic              ovf_q;
  logic              v1;
  logic              v2;
  logic              wr1;
  logic              wr2;
  logic              pop;
  logic [1:0]        writes;
  logic [1:0]        drops;

  // PE handshake: pe_flit/pe_valid are presented whenever the FIFO holds data; a transfer
  // happens on any rising edge where pe_valid & pe_ready, and pe_flit holds until then.
  assign pe_valid  = (occ_q != '0);
  assign pe_flit   = pe_valid ? mem[rd_ptr] : '0;
  assign pop       = pe_valid & pe_ready;
  assign occupancy = occ_q;
  assign drop_cnt  = drop_q;
  assign overflow  = ovf_q;

  assign v1 = ej_flit1[FLIT_W-1];
  assign v2 = ej_flit2[FLIT_W-1];

  // A popping entry frees its slot for a write in the same cycle.
  assign space = DEPTH_V - {1'b0, occ_q} + {{(PTR_W+1){1'b0}}, pop};

  always_comb begin
    wr1 = 1'b0;
    wr2 = 1'b0;
    if (v1 && (space >= (PTR_W+2)'(1))) wr1 = 1'b1;
    if (v2 && (space >= ((PTR_W+2)'(1) + (PTR_W+2)'(wr1)))) wr2 = 1'b1;
  end

  assign writes   = {1'b0, wr1} + {1'b0, wr2};
  assign drops    = {1'b0, v1 & ~wr1} + {1'b0, v2 & ~wr2};
  assign wr_ptr2  = wr_ptr + PTR_W'(wr1);
  assign occ_next = occ_q + (PTR_W+1)'(writes) - (PTR_W+1)'(pop);
  assign drop_sum = {1'b0, drop_q} + 17'(drops);

  // Storage is deliberately not reset; pe_flit is masked while empty instead.
  always_ff @(posedge clk) begin
    if (wr1) mem[wr_ptr] <= ej_flit1;
    if (wr2) mem[wr_ptr2] <= ej_flit2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(writes);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      occ_q  <= occ_next;
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      // A drop in the same cycle as a clear keeps the flag set.
      if (drops != 2'd0)    ovf_q <= 1'b1;
      else if (clr_overflow) ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multinoc_eject_ni.sv
// Directed bench for multinoc_eject_ni: single/dual arrivals, fill and overflow, pop-at-full,
// pointer wrap, sticky overflow, drop-counter saturation and asynchronous reset.
module tb_multinoc_eject_ni;

  localparam int FLIT_W = 16;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;

  logic              clk;
  logic              reset;
  logic [FLIT_W-1:0] ej_flit1;
  logic [FLIT_W-1:0] ej_flit2;
  logic [FLIT_W-1:0] pe_flit;
  logic              pe_valid;
  logic              pe_ready;
  logic [PTR_W:0]    occupancy;
  logic [15:0]       drop_cnt;
  logic              overflow;
  logic              clr_overflow;

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [FLIT_W-1:0] exp_q[$];
  logic [FLIT_W-1:0] exp_v;

  multinoc_eject_ni #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .ej_flit1(ej_flit1), .ej_flit2(ej_flit2),
    .pe_flit(pe_flit), .pe_valid(pe_valid), .pe_ready(pe_ready),
    .occupancy(occupancy), .drop_cnt(drop_cnt), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [FLIT_W-1:0] f1, input logic [FLIT_W-1:0] f2);
    ej_flit1 = f1;
    ej_flit2 = f2;
  endtask

  initial begin
    reset = 1'b0; pe_ready = 1'b0; clr_overflow = 1'b0;
    drive('0, '0);
    repeat (3) step();
    check("rst_occ", 32'(occupancy), 0);
    check("rst_valid", 32'(pe_valid), 0);
    check("rst_flit", 32'(pe_flit), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_ovf", 32'(overflow), 0);
    reset = 1'b1;
    step();

    // Single flit with PE ready
    pe_ready = 1'b1;
    drive(16'h80A1, '0);
    step();
    drive('0, '0);
    check("t1_valid", 32'(pe_valid), 1);
    check("t1_flit", 32'(pe_flit), 32'h80A1);
    check("t1_occ", 32'(occupancy), 1);
    step();
    check("t1_valid_after", 32'(pe_valid), 0);
    check("t1_occ_after", 32'(occupancy), 0);

    // Flit without its valid bit is ignored
    drive(16'h1234, 16'h7FFF);
    step();
    drive('0, '0);
    check("inv_occ", 32'(occupancy), 0);

    // Simultaneous pair, PE stalled, then drained A then B
    pe_ready = 1'b0;
    drive(16'h80B1, 16'h80B2);
    step();
    drive('0, '0);
    check("t2_occ", 32'(occupancy), 2);
    check("t2_head", 32'(pe_flit), 32'h80B1);
    step();
    check("t2_stable", 32'(pe_flit), 32'h80B1);
    pe_ready = 1'b1;
    step();
    check("t2_second", 32'(pe_flit), 32'h80B2);
    check("t2_occ1", 32'(occupancy), 1);
    step();
    check("t2_empty", 32'(pe_valid), 0);

    // Stream of single flits across pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(16'h8100 + 16'(i), '0);
      step();
      check("t5_order", 32'(pe_flit), 32'h8100 + 32'(i));
    end
    drive('0, '0);
    step();
    check("t5_occ", 32'(occupancy), 0);
    check("t5_drop", 32'(drop_cnt), 0);

    // Fill with four pairs, then one more pair overflows
    pe_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(16'h8000 + 16'(2*k), 16'h8000 + 16'(2*k+1));
      exp_q.push_back(16'h8000 + 16'(2*k));
      exp_q.push_back(16'h8000 + 16'(2*k+1));
      step();
    end
    check("t3_full_occ", 32'(occupancy), 8);
    check("t3_no_drop", 32'(drop_cnt), 0);
    drive(16'h80F0, 16'h80F1);
    step();
    check("t3_occ", 32'(occupancy), 8);
    check("t3_drop", 32'(drop_cnt), 2);
    check("t3_ovf", 32'(overflow), 1);
    check("t3_head", 32'(pe_flit), 32'h8000);

    // Pop at full: plane-1 takes the freed slot, plane-2 dropped
    pe_ready = 1'b1;
    drive(16'h80E0, 16'h80E1);
    void'(exp_q.pop_front());
    exp_q.push_back(16'h80E0);
    step();
    drive('0, '0);
    check("t4_occ", 32'(occupancy), 8);
    check("t4_drop", 32'(drop_cnt), 3);
    for (int i = 0; i < 8; i++) begin
      exp_v = exp_q.pop_front();
      check("t4_drain", 32'(pe_flit), 32'(exp_v));
      step();
    end
    check("t4_empty", 32'(occupancy), 0);
    pe_ready = 1'b0;

    // Sticky overflow cleared, count held
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("t6_clr_ovf", 32'(overflow), 0);
    check("t6_clr_drop", 32'(drop_cnt), 3);

    // Clear coinciding with a drop keeps overflow set
    for (int k = 0; k < 4; k++) begin
      drive(16'h8200 + 16'(2*k), 16'h8200 + 16'(2*k+1));
      step();
    end
    drive(16'h8210, 16'h8211);
    clr_overflow = 1'b1;
    step();
    drive('0, '0);
    check("t6_set_wins", 32'(overflow), 1);
    check("t6_drop5", 32'(drop_cnt), 5);
    step();
    clr_overflow = 1'b0;
    check("t6_clr_later", 32'(overflow), 0);

    // Drive the drop counter to FFFE, then saturate
    drive(16'h8300, 16'h8301);
    for (int i = 0; i < 32764; i++) step();
    drive(16'h8302, '0);
    step();
    check("sat_fffe", 32'(drop_cnt), 32'hFFFE);
    drive(16'h8303, 16'h8304);
    step();
    check("sat_ffff", 32'(drop_cnt), 32'hFFFF);
    step();
    check("sat_hold", 32'(drop_cnt), 32'hFFFF);
    check("sat_occ", 32'(occupancy), 8);

    // Asynchronous reset mid-stream, observed before the next clock edge
    reset = 1'b0;
    #2;
    check("arst_valid", 32'(pe_valid), 0);
    check("arst_occ", 32'(occupancy), 0);
    check("arst_drop", 32'(drop_cnt), 0);
    check("arst_ovf", 32'(overflow), 0);
    check("arst_flit", 32'(pe_flit), 0);
    drive('0, '0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_occ", 32'(occupancy), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
